// File: rtl/c3lib_bintogray.sv
// Combinational binary-to-Gray encoder.
module c3lib_bintogray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  assign data_out = data_in ^ (data_in >> 1);

endmodule

// File: rtl/c3lib_graycnt.sv
// Binary/Gray pointer counter for clock-domain-crossing FIFOs. The Gray pointer
// is a bare flop output so it can feed a synchronizer directly.
module c3lib_graycnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_ptr,
  output logic [WIDTH-1:0] gray_ptr,
  output logic [WIDTH-1:0] bin_nxt,
  output logic [WIDTH-1:0] gray_nxt,
  output logic             wrap_pls
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_ptr_q, bin_ptr_d;
  logic [WIDTH-1:0] gray_ptr_q, gray_ptr_d;
  logic             wrap_pls_q, wrap_pls_d;

  always_comb begin
    bin_ptr_d  = bin_ptr_q;
    wrap_pls_d = 1'b0;
    if (clr) begin
      bin_ptr_d = '0;
    end else if (inc_en) begin
      bin_ptr_d  = bin_ptr_q + ONE;
      wrap_pls_d = &bin_ptr_q;
    end
  end

  // Encode the next value so the registered Gray pointer has no logic after the flop.
  c3lib_bintogray #(.WIDTH(WIDTH)) u_bintogray (
    .data_in  (bin_ptr_d),
    .data_out (gray_ptr_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_ptr_q  <= '0;
      gray_ptr_q <= '0;
      wrap_pls_q <= 1'b0;
    end else begin
      bin_ptr_q  <= bin_ptr_d;
      gray_ptr_q <= gray_ptr_d;
      wrap_pls_q <= wrap_pls_d;
    end
  end

  assign bin_ptr  = bin_ptr_q;
  assign gray_ptr = gray_ptr_q;
  assign bin_nxt  = bin_ptr_d;
  assign gray_nxt = gray_ptr_d;
  assign wrap_pls = wrap_pls_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    a_width_legal: assert (WIDTH >= 2 && WIDTH <= 16);
    if (rst_n) begin
      a_gray_match: assert (gray_ptr_q == (bin_ptr_q ^ (bin_ptr_q >> 1)));
      if (!clr) begin
        a_one_bit_step: assert ($countones(gray_ptr_q ^ gray_ptr_d) <= 1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_c3lib_graycnt.sv
// Self-checking bench: directed vector table at WIDTH=4, async reset corners,
// and a random scoreboard run across WIDTH=2/4/8 instances.
module tb_c3lib_graycnt;

  logic clk, clk_run, rst_n, inc_en, clr;

  logic [1:0] b2, g2, bn2, gn2;
  logic [3:0] b4, g4, bn4, gn4;
  logic [7:0] b8, g8, bn8, gn8;
  logic       w2, w4, w8;

  c3lib_graycnt #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .inc_en(inc_en), .clr(clr),
    .bin_ptr(b2), .gray_ptr(g2), .bin_nxt(bn2), .gray_nxt(gn2), .wrap_pls(w2));
  c3lib_graycnt #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .inc_en(inc_en), .clr(clr),
    .bin_ptr(b4), .gray_ptr(g4), .bin_nxt(bn4), .gray_nxt(gn4), .wrap_pls(w4));
  c3lib_graycnt #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .inc_en(inc_en), .clr(clr),
    .bin_ptr(b8), .gray_ptr(g8), .bin_nxt(bn8), .gray_nxt(gn8), .wrap_pls(w8));

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  typedef struct {
    logic       inc;
    logic       clr;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
  } vec_t;

  typedef struct {
    logic [7:0] b2, g2, b4, g4, b8, g8;
    logic       w2, w4, w8;
  } rexp_t;

  int checks = 0;
  int errors = 0;

  vec_t  vecs[$];
  vec_t  vq[$];
  rexp_t rq[$];

  logic [3:0] gray4_lut [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] seq17 [17] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD,
                             4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkv(logic inc, logic c, logic [3:0] b, logic [3:0] g, logic w);
    vec_t v;
    v.inc = inc; v.clr = c; v.bin = b; v.gray = g; v.wrap = w;
    return v;
  endfunction

  function automatic logic [7:0] to_gray(logic [7:0] b);
    logic [7:0] g;
    g[7] = b[7];
    for (int i = 0; i < 7; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  initial begin
    vec_t  v;
    rexp_t r;
    logic [7:0] m2, m4, m8;

    clk_run = 1'b0;
    rst_n   = 1'b0;
    inc_en  = 1'b0;
    clr     = 1'b0;

    // Reset with the clock stopped, then release with an increment pending.
    #12;
    chk("rst_bin", b4, 0);
    chk("rst_gray", g4, 0);
    chk("rst_wrap", w4, 0);
    inc_en  = 1'b1;
    rst_n   = 1'b1;
    clk_run = 1'b1;
    tick();
    chk("first_inc_bin", b4, 1);
    chk("first_inc_gray", g4, 1);

    // Directed table: full lap, step to 6, hold, step to F, clear vs inc.
    for (int k = 1; k <= 17; k++) vecs.push_back(mkv(1, 0, 4'(k), seq17[k-1], k == 16));
    for (int b = 2; b <= 6; b++) vecs.push_back(mkv(1, 0, 4'(b), gray4_lut[b], 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mkv(0, 0, 4'h6, 4'h5, 0));
    for (int b = 7; b <= 15; b++) vecs.push_back(mkv(1, 0, 4'(b), gray4_lut[b], 0));
    vecs.push_back(mkv(1, 1, 4'h0, 4'h0, 0));
    vecs.push_back(mkv(0, 0, 4'h0, 4'h0, 0));
    vecs.push_back(mkv(1, 0, 4'h1, 4'h1, 0));

    pulse_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      inc_en = vecs[i].inc;
      clr    = vecs[i].clr;
      vq.push_back(vecs[i]);
      tick();
      v = vq.pop_front();
      chk($sformatf("vec%0d_bin", i), b4, v.bin);
      chk($sformatf("vec%0d_gray", i), g4, v.gray);
      chk($sformatf("vec%0d_wrap", i), w4, v.wrap);
    end

    // Async reset between edges at bin_ptr=9.
    clr = 1'b0;
    pulse_reset();
    inc_en = 1'b1;
    repeat (9) tick();
    chk("pre_async_bin", b4, 9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_bin", b4, 0);
    chk("async_gray", g4, 0);
    chk("async_wrap", w4, 0);
    rst_n  = 1'b1;
    inc_en = 1'b0;
    tick();
    chk("post_async_bin", b4, 0);

    // Random scoreboard across three widths.
    pulse_reset();
    m2 = 0; m4 = 0; m8 = 0;
    for (int n = 0; n < 10000; n++) begin
      inc_en = ($urandom_range(0, 9) < 7);
      clr    = ($urandom_range(0, 19) == 0);
      r.w2 = 0; r.w4 = 0; r.w8 = 0;
      if (clr) begin
        m2 = 0; m4 = 0; m8 = 0;
      end else if (inc_en) begin
        r.w2 = (m2 == 8'h03);
        r.w4 = (m4 == 8'h0F);
        r.w8 = (m8 == 8'hFF);
        m2 = (m2 + 8'd1) & 8'h03;
        m4 = (m4 + 8'd1) & 8'h0F;
        m8 = m8 + 8'd1;
      end
      r.b2 = m2; r.g2 = to_gray(m2);
      r.b4 = m4; r.g4 = to_gray(m4);
      r.b8 = m8; r.g8 = to_gray(m8);
      rq.push_back(r);
      #1;
      chk("rnd_nxt_bin4", bn4, r.b4);
      chk("rnd_nxt_gray4", gn4, r.g4);
      chk("rnd_nxt_bin8", bn8, r.b8);
      chk("rnd_nxt_gray2", gn2, r.g2);
      tick();
      r = rq.pop_front();
      chk("rnd_bin2", b2, r.b2);
      chk("rnd_gray2", g2, r.g2);
      chk("rnd_wrap2", w2, r.w2);
      chk("rnd_bin4", b4, r.b4);
      chk("rnd_gray4", g4, r.g4);
      chk("rnd_wrap4", w4, r.w4);
      chk("rnd_bin8", b8, r.b8);
      chk("rnd_gray8", g8, r.g8);
      chk("rnd_wrap8", w8, r.w8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
